barrel_shifter_pipe: RTL and testbench
======================================

// Module: barrel_shifter_pipe
// PURPOSE
//  Parametrised, fully pipelined barrel shifter with valid/ready flow control.
//  Supports five modes: logical left, logical right, arithmetic right, rotate left and rotate right.
//  Shift amount, mode and sideband tag travel with the data through every stage.
//  Sits between operand issue and the ALU result mux; accepts one operation per clock.
// PARAMETERS
//  WIDTH  32  data width; power of two, >= 2
//  TAG_W  4   width of the opaque sideband tag carried with each operation
//  SHW    $clog2(WIDTH)  localparam: shift-amount width and number of pipeline stages
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       operation offered
//  in_ready   out  1       block can accept; a transfer occurs when in_valid & in_ready at the clk edge
//  in_data    in   WIDTH   operand
//  in_shamt   in   SHW     shift amount, 0..WIDTH-1
//  in_mode    in   3       000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved
//  in_tag     in   TAG_W   sideband, returned unchanged
//  out_valid  out  1       result available
//  out_ready  in   1       consumer accepts; a transfer occurs when out_valid & out_ready
//  out_data   out  WIDTH   shifted result
//  out_tag    out  TAG_W   tag of this result
//  out_err    out  1       1 = reserved mode; data passed through unshifted
// BEHAVIOUR
//  - Reset: all stage valid bits clear; out_valid=0, out_data=0, out_tag=0, out_err=0.
//    in_ready=0 while rst=1. In-flight items are discarded and never appear after reset.
//  - Pipeline: SHW registered stages. Stage k applies a shift of 2^k when shamt bit k=1, else passes data.
//    Each stage registers data, shamt, mode, tag, err and valid. Control is never sampled from the input port after acceptance.
//  - Latency: an item accepted at edge t is presented at out_* after edge t+SHW-1, i.e. SHW clk edges including the accept edge
//    (5 for WIDTH=32) when no stall occurs. Throughput is 1 item per cycle.
//  - Flow control, per stage: rdy[k] = !v[k] | rdy[k+1], with rdy[SHW] = out_ready and in_ready = rdy[0] & !rst.
//    A stage loads only when rdy[k]=1. Bubbles collapse. Order is preserved; no item is dropped or duplicated.
//  - Held output: while out_valid=1 and out_ready=0, out_data, out_tag and out_err are stable.
//  - Simultaneous events: a stage may hand off and reload in the same cycle (full pipe with out_ready=1 accepts a new item every cycle).
//  - Fill values:
//    - SLL and SRL fill with 0.
//    - SRA fills with in_data[WIDTH-1], the sign sampled at acceptance.
//    - ROL and ROR wrap bits modulo WIDTH.
//  - shamt=0 returns in_data unchanged in every mode. shamt=WIDTH-1 is the maximum; there is no wrap of the shift amount itself.
//  - Reserved mode: the shift is suppressed at every stage, out_data = in_data, out_err=1. Pipeline timing is unchanged.
//  - Reset mid-operation takes priority over any transfer in the same cycle.
// STRUCTURE
//  - Shared package: mode encodings (MODE_SLL..MODE_ROR) and an is_reserved() helper.
//  - One sub-module, shift_stage (parameters WIDTH, TAG_W, STEP):
//    - one combinational stage shifting by STEP, plus its valid/ready register slice;
//    - the top level is a generate loop of SHW instances with STEP = 2^k.
//  - Right modes are handled inside shift_stage by direction select; no bit-reversal wrapper is used.
// TESTING (WIDTH=32 unless noted; a second regression runs WIDTH=8)
//  1. SLL 32'h0000_0001, shamt 31 -> 32'h8000_0000 exactly 5 cycles later; shamt 0 -> 32'h0000_0001.
//  2. SRA 32'h8000_0000, shamt 4 -> 32'hF800_0000; SRL same operand -> 32'h0800_0000.
//  3. ROL 32'h8000_0001, shamt 1 -> 32'h0000_0003; ROR 32'h0000_0001, shamt 1 -> 32'h8000_0000.
//  4. 8 back-to-back items with tags 0..7, out_ready=0 on cycles 3-6:
//     all emerge in tag order with correct data; in_ready drops once 5 items are held; no loss or duplication.
//  5. rst pulsed for 1 cycle with 3 items in flight -> out_valid=0 next cycle; no stale item emerges afterwards.
//  6. Mode 3'b111, 32'h1234_5678, shamt 8 -> out_data 32'h1234_5678 with out_err=1. A following SLL item has out_err=0.

Source files
------------

// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and
// a helper that flags the reserved mode codes.
package barrel_shifter_pipe_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_SLL = 3'b000,
    MODE_SRL = 3'b001,
    MODE_SRA = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100
  } mode_e;

  // Codes above ROR carry no shift meaning; the data is passed through untouched.
  function automatic logic is_reserved(input logic [MODE_W-1:0] mode);
    return (mode > 3'b100);
  endfunction

endpackage : barrel_shifter_pipe_pkg

// File: rtl/barrel_shifter_pipe_shift_stage.sv
// One pipeline slice of the barrel shifter: a fixed shift by STEP (applied
// when the matching shift-amount bit is set) followed by a valid/ready
// register slice that carries data and all control with the item.
module shift_stage
  import barrel_shifter_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int STEP  = 1,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  // upstream side
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [WIDTH-1:0]  up_data,
  input  logic [SHW-1:0]    up_shamt,
  input  logic [MODE_W-1:0] up_mode,
  input  logic [TAG_W-1:0]  up_tag,
  input  logic              up_err,
  // downstream side
  input  logic              dn_ready,
  output logic              dn_valid,
  output logic [WIDTH-1:0]  dn_data,
  output logic [SHW-1:0]    dn_shamt,
  output logic [MODE_W-1:0] dn_mode,
  output logic [TAG_W-1:0]  dn_tag,
  output logic              dn_err
);

  // Shift-amount bit that enables this stage.
  localparam int BIT = $clog2(STEP);

  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q,  data_d;
  logic [SHW-1:0]    shamt_q, shamt_d;
  logic [MODE_W-1:0] mode_q,  mode_d;
  logic [TAG_W-1:0]  tag_q,   tag_d;
  logic              err_q,   err_d;
  logic [WIDTH-1:0]  shifted_s;

  // The slice can take a new item when empty or when its item leaves this cycle.
  assign up_ready = !valid_q || dn_ready;

  // Fixed-distance shift; direction chosen by mode, suppressed for reserved modes.
  always_comb begin
    shifted_s = up_data;
    if (up_shamt[BIT] && !up_err) begin
      case (up_mode)
        MODE_SLL: shifted_s = up_data << STEP;
        MODE_SRL: shifted_s = up_data >> STEP;
        // The MSB is still the original sign: earlier stages keep it in place.
        MODE_SRA: shifted_s = $signed(up_data) >>> STEP;
        MODE_ROL: shifted_s = (up_data << STEP) | (up_data >> (WIDTH - STEP));
        MODE_ROR: shifted_s = (up_data >> STEP) | (up_data << (WIDTH - STEP));
        default:  shifted_s = up_data;
      endcase
    end else begin
      shifted_s = up_data;
    end
  end

  // Next-state of the register slice: valid follows upstream when ready,
  // payload is captured only on a real transfer so a held item never changes.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    err_d   = err_q;
    if (up_ready) begin
      valid_d = up_valid;
    end else begin
      valid_d = valid_q;
    end
    if (up_ready && up_valid) begin
      data_d  = shifted_s;
      shamt_d = up_shamt;
      mode_d  = up_mode;
      tag_d   = up_tag;
      err_d   = up_err;
    end else begin
      data_d  = data_q;
      shamt_d = shamt_q;
      mode_d  = mode_q;
      tag_d   = tag_q;
      err_d   = err_q;
    end
  end

  // Slice registers; reset empties the slice and clears the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      mode_q  <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;
  assign dn_shamt = shamt_q;
  assign dn_mode  = mode_q;
  assign dn_tag   = tag_q;
  assign dn_err   = err_q;

endmodule : shift_stage

// File: rtl/barrel_shifter_pipe.sv
// Fully pipelined barrel shifter: SHW chained shift_stage slices, stage k
// shifting by 2^k. One operation per clock, order preserving, with
// per-stage valid/ready so bubbles collapse under backpressure.
module barrel_shifter_pipe
  import barrel_shifter_pipe_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  TAG_W = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]    in_shamt,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  // Index k is the input of stage k; index SHW is the last stage's output.
  logic              valid_a [SHW+1];
  logic              rdy_a   [SHW+1];
  logic [WIDTH-1:0]  data_a  [SHW+1];
  logic [SHW-1:0]    shamt_a [SHW+1];
  logic [MODE_W-1:0] mode_a  [SHW+1];
  logic [TAG_W-1:0]  tag_a   [SHW+1];
  logic              err_a   [SHW+1];

  assign valid_a[0] = in_valid;
  assign data_a[0]  = in_data;
  assign shamt_a[0] = in_shamt;
  assign mode_a[0]  = in_mode;
  assign tag_a[0]   = in_tag;
  assign err_a[0]   = is_reserved(in_mode);

  assign rdy_a[SHW] = out_ready;
  assign in_ready   = rdy_a[0] & ~rst;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .STEP  (2**k),
      .SHW   (SHW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (valid_a[k]),
      .up_ready (rdy_a[k]),
      .up_data  (data_a[k]),
      .up_shamt (shamt_a[k]),
      .up_mode  (mode_a[k]),
      .up_tag   (tag_a[k]),
      .up_err   (err_a[k]),
      .dn_ready (rdy_a[k+1]),
      .dn_valid (valid_a[k+1]),
      .dn_data  (data_a[k+1]),
      .dn_shamt (shamt_a[k+1]),
      .dn_mode  (mode_a[k+1]),
      .dn_tag   (tag_a[k+1]),
      .dn_err   (err_a[k+1])
    );
  end

  // Outputs come straight from the last slice's registers.
  assign out_valid = valid_a[SHW];
  assign out_data  = data_a[SHW];
  assign out_tag   = tag_a[SHW];
  assign out_err   = err_a[SHW];

  // Shift amount and mode are spent once the last stage has acted.
  logic unused_ctl_s;
  assign unused_ctl_s = ^{shamt_a[SHW], mode_a[SHW]};

endmodule : barrel_shifter_pipe

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe (WIDTH=32): directed cases
// plus randomized traffic checked by a queue-based reference model.
module tb_barrel_shifter_pipe;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int SH = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SH-1:0] in_shamt = '0;
  logic [2:0]    in_mode = 3'd0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_err;

  int total = 0;
  int bad   = 0;
  logic rand_rdy = 1'b0;

  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
    logic          e;
  } exp_t;
  exp_t q[$];

  logic          hold_v = 1'b0;
  logic [W-1:0]  hold_d;
  logic [TW-1:0] hold_t;
  logic          hold_e;

  barrel_shifter_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bit-by-bit reference: where does each result bit come from.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int sh, input logic [2:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      case (m)
        3'd0: r[i] = (i >= sh) ? d[i-sh] : 1'b0;
        3'd1: r[i] = (i + sh < W) ? d[i+sh] : 1'b0;
        3'd2: r[i] = (i + sh < W) ? d[i+sh] : d[W-1];
        3'd3: r[i] = d[(i - sh + W) % W];
        3'd4: r[i] = d[(i + sh) % W];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  // Scoreboard: evaluate both handshakes mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check_val("hold_data", {32'd0, out_data}, {32'd0, hold_d});
        check_val("hold_tag", {60'd0, out_tag}, {60'd0, hold_t});
        check_val("hold_err", {63'd0, out_err}, {63'd0, hold_e});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_val("unexpected_out", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_val("sb_data", {32'd0, out_data}, {32'd0, e.d});
          check_val("sb_tag", {60'd0, out_tag}, {60'd0, e.t});
          check_val("sb_err", {63'd0, out_err}, {63'd0, e.e});
        end
      end
      if (in_valid && in_ready) begin
        exp_t n;
        n.d = ref_shift(in_data, int'(in_shamt), in_mode);
        n.t = in_tag;
        n.e = (in_mode > 3'd4);
        q.push_back(n);
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_t = out_tag;
      hold_e = out_err;
    end
  end

  task automatic send(input logic [W-1:0] d, input int sh, input logic [2:0] m, input logic [TW-1:0] t);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = SH'(sh);
    in_mode  = m;
    in_tag   = t;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      n++;
      if (n > 200) begin
        check_val("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] d, input logic e);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check_val({tag, "_data"}, {32'd0, out_data}, {32'd0, d});
    check_val({tag, "_err"}, {63'd0, out_err}, {63'd0, e});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 64'(q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_out_data", {32'd0, out_data}, 64'd0);
    check_val("rst_out_tag", {60'd0, out_tag}, 64'd0);
    check_val("rst_out_err", {63'd0, out_err}, 64'd0);
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Latency: out_valid appears after the fifth edge counting the accept edge
    send(32'h0000_0001, 31, 3'd0, 4'd1);
    repeat (3) @(posedge clk);
    #1;
    check_val("lat_early", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check_val("lat_valid", {63'd0, out_valid}, 64'd1);
    check_val("lat_data", {32'd0, out_data}, 64'h0000_0000_8000_0000);
    drain("drain_lat");

    send(32'h0000_0001, 0, 3'd0, 4'd2);
    expect_out("sll0", 32'h0000_0001, 1'b0);
    send(32'h8000_0000, 4, 3'd2, 4'd3);
    expect_out("sra4", 32'hF800_0000, 1'b0);
    send(32'h8000_0000, 4, 3'd1, 4'd4);
    expect_out("srl4", 32'h0800_0000, 1'b0);
    send(32'h8000_0001, 1, 3'd3, 4'd5);
    expect_out("rol1", 32'h0000_0003, 1'b0);
    send(32'h0000_0001, 1, 3'd4, 4'd6);
    expect_out("ror1", 32'h8000_0000, 1'b0);
    send(32'h1234_5678, 8, 3'd7, 4'd7);
    expect_out("resv", 32'h1234_5678, 1'b1);
    send(32'h1234_5678, 8, 3'd0, 4'd8);
    expect_out("after_resv", 32'h3456_7800, 1'b0);
    drain("drain_dir");

    // Backpressure: five items fill the pipe, the sixth is refused
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send($urandom, $urandom_range(0, W-1), 3'($urandom_range(0, 4)), TW'(i));
    in_valid = 1'b1;
    in_tag   = 4'd5;
    @(negedge clk);
    check_val("full_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 5; i < 8; i++) send($urandom, $urandom_range(0, W-1), 3'($urandom_range(0, 4)), TW'(i));
    drain("drain_bp");

    // Reset with items in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom, $urandom_range(0, W-1), 3'd0, TW'(9 + i));
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check_val("no_stale", {63'd0, out_valid}, 64'd0);
    end

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send($urandom, $urandom_range(0, W-1), 3'($urandom_range(0, 7)), TW'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain("drain_rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_barrel_shifter_pipe
